// File: rtl/instr_loader.sv
// instr_loader: assembles a byte stream (MSB first) into 32-bit instruction
// words and writes them to instruction memory until a 32'hFFFFFFFF
// terminator is written or the last memory word has been filled.
// Optional feature: define LOADER_CHECKSUM_EN to build the running XOR
// checksum of written words; otherwise the checksum port is tied to 0.
module instr_loader #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [31:0]       TERMINATOR = 32'hFFFF_FFFF;

  state_t              state_r;
  state_t              next_state_s;
  // Only the first three bytes need storing; the fourth goes straight into wr_data.
  logic [23:0]         asm_r;
  logic [1:0]          byte_cnt_r;
  logic                accept_s;
  logic                last_byte_s;
  logic                start_s;
  logic                is_term_s;
  logic                at_last_addr_s;
  logic                set_overflow_s;

  // Decode handshake, session start and write-termination conditions.
  always_comb begin
    accept_s       = byte_valid & byte_ready;
    last_byte_s    = accept_s & (byte_cnt_r == 2'd3);
    start_s        = start & ((state_r == IDLE) | (state_r == DONE));
    is_term_s      = (wr_data == TERMINATOR);
    at_last_addr_s = (wr_addr == LAST_ADDR);
    set_overflow_s = (state_r == WRITE) & ~is_term_s & at_last_addr_s;
  end

  // Next-state logic for the load session FSM.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = COLLECT;
        else       next_state_s = IDLE;
      end
      COLLECT: begin
        if (last_byte_s) next_state_s = WRITE;
        else             next_state_s = COLLECT;
      end
      WRITE: begin
        if (is_term_s || at_last_addr_s) next_state_s = DONE;
        else                             next_state_s = COLLECT;
      end
      DONE: begin
        if (start) next_state_s = COLLECT;
        else       next_state_s = DONE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLOCK) begin
    if (RESET) state_r <= IDLE;
    else       state_r <= next_state_s;
  end

  // Datapath and registered outputs: byte assembly, write strobe, counters, status.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= {ADDR_W{1'b0}};
      wr_data    <= 32'h0000_0000;
      done       <= 1'b0;
      overflow   <= 1'b0;
      word_count <= {(ADDR_W+1){1'b0}};
      asm_r      <= 24'h00_0000;
      byte_cnt_r <= 2'd0;
    end else begin
      byte_ready <= (next_state_s == COLLECT);
      wr_en      <= (next_state_s == WRITE);
      done       <= (next_state_s == DONE);
      if (start_s) begin
        word_count <= {(ADDR_W+1){1'b0}};
        byte_cnt_r <= 2'd0;
        overflow   <= 1'b0;
      end
      if (accept_s) begin
        asm_r      <= {asm_r[15:0], byte_in};
        byte_cnt_r <= byte_cnt_r + 2'd1;
        if (last_byte_s) begin
          wr_addr <= word_count[ADDR_W-1:0];
          wr_data <= {asm_r, byte_in};
        end
      end
      if (state_r == WRITE) begin
        word_count <= word_count + (ADDR_W+1)'(1);
        if (set_overflow_s) overflow <= 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  function automatic logic [31:0] xor_fold(input logic [31:0] acc, input logic [31:0] word);
    return acc ^ word;
  endfunction

  // Running XOR of every word written in the current session, terminator included.
  always_ff @(posedge CLOCK) begin
    if (RESET)                 checksum <= 32'h0000_0000;
    else if (start_s)          checksum <= 32'h0000_0000;
    else if (state_r == WRITE) checksum <= xor_fold(checksum, wr_data);
    else                       checksum <= checksum;
  end
`else
  assign checksum = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader. A reference model derives, from the
// word list of each session, the writes, overflow, word count and checksum.
module tb_instr_loader;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 3;

  logic              CLOCK = 1'b0;
  logic              RESET;
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              done;
  logic              overflow;
  logic [ADDR_W:0]   word_count;
  logic [31:0]       checksum;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] stim[$];
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  bit          exp_ovf;
  logic [31:0] exp_ck;
  int          got_addr[$];
  logic [31:0] got_data[$];
  logic        prev_wr = 1'b0;

  instr_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .done(done), .overflow(overflow),
    .word_count(word_count), .checksum(checksum)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: records every write and checks the strobe is one cycle wide.
  always @(negedge CLOCK) begin
    if (wr_en === 1'b1) begin
      chk("wr_en_width", {63'd0, prev_wr}, 64'd0);
      got_addr.push_back(int'(wr_addr));
      got_data.push_back(wr_data);
    end
    prev_wr = wr_en;
  end

  task automatic tick();
    @(posedge CLOCK);
    @(negedge CLOCK);
  endtask

  task automatic do_reset();
    RESET = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    tick(); tick();
    RESET = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    int guard = 0;
    byte_in = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    if (byte_ready !== 1'b1) begin
      chk("byte_ready_timeout", {63'd0, byte_ready}, 64'd1);
      byte_valid = 1'b0;
      return;
    end
    tick();
    byte_valid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      byte_in = 8'($urandom);
      tick();
    end
  endtask

  // mode 0: back-to-back, 1: valid toggles every cycle, 2: random gaps.
  task automatic send_word(input logic [31:0] w, input int mode);
    for (int k = 0; k < 4; k++) begin
      int st;
      st = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
      send_byte(w[31-8*k -: 8], st);
    end
  endtask

  // Reference model: words are written at consecutive addresses from 0 until
  // the terminator (written) or until address DEPTH-1 is filled (overflow).
  task automatic build_expect();
    exp_addr.delete(); exp_data.delete();
    exp_ovf = 1'b0;
    exp_ck  = 32'h0;
    foreach (stim[i]) begin
      exp_addr.push_back(i);
      exp_data.push_back(stim[i]);
      exp_ck = exp_ck ^ stim[i];
      if (stim[i] == 32'hFFFF_FFFF) break;
      if (i == DEPTH - 1) begin
        exp_ovf = 1'b1;
        break;
      end
    end
`ifndef LOADER_CHECKSUM_EN
    exp_ck = 32'h0;
`endif
  endtask

  task automatic begin_session();
    build_expect();
    got_addr.delete(); got_data.delete();
    pulse_start();
  endtask

  task automatic end_session(input string tag);
    int g = 0;
    while (done !== 1'b1 && g < 30) begin
      tick();
      g++;
    end
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    chk({tag, "_overflow"}, {63'd0, overflow}, {63'd0, exp_ovf});
    chk({tag, "_word_count"}, 64'(word_count), 64'(exp_addr.size()));
    chk({tag, "_checksum"}, 64'(checksum), 64'(exp_ck));
    chk({tag, "_n_writes"}, 64'(got_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (i < got_addr.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), 64'(got_addr[i]), 64'(exp_addr[i]));
        chk($sformatf("%s_data%0d", tag, i), 64'(got_data[i]), 64'(exp_data[i]));
      end
    end
  endtask

  task automatic run_session(input string tag, input int mode);
    begin_session();
    foreach (exp_data[i]) send_word(exp_data[i], mode);
    end_session(tag);
  endtask

  initial begin
    do_reset();
    chk("rst_byte_ready", {63'd0, byte_ready}, 64'd0);
    chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    chk("rst_word_count", 64'(word_count), 64'd0);
    chk("rst_checksum", 64'(checksum), 64'd0);

    // Basic two-word session.
    stim = '{32'h0000_0020, 32'hFFFF_FFFF};
    run_session("basic", 0);

    // Valid toggling every cycle.
    stim = '{32'hA5C3_0F12, 32'h0000_0020, 32'hFFFF_FFFF};
    run_session("toggle", 1);

    // Memory fills without a terminator.
    stim = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004, 32'hFFFF_FFFF};
    run_session("overflow", 0);

    // Terminator landing exactly on the last address.
    stim = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'hFFFF_FFFF};
    run_session("term_last", 0);

    // Checksum pattern.
    stim = '{32'h0000_000F, 32'h0000_00F0, 32'hFFFF_FFFF};
    run_session("cksum", 0);
`ifdef LOADER_CHECKSUM_EN
    chk("cksum_const", 64'(checksum), 64'h0000_0000_FFFF_FF00);
`else
    chk("cksum_const", 64'(checksum), 64'd0);
`endif

    // Reset mid-word abandons the partial word.
    got_addr.delete(); got_data.delete();
    pulse_start();
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    do_reset();
    chk("midrst_n_writes", 64'(got_addr.size()), 64'd0);
    chk("midrst_word_count", 64'(word_count), 64'd0);
    chk("midrst_byte_ready", {63'd0, byte_ready}, 64'd0);
    stim = '{32'h1234_5678, 32'hFFFF_FFFF};
    run_session("after_rst", 0);

    // start in COLLECT is ignored; byte position is kept.
    stim = '{32'h1122_3344, 32'hABCD_EF01, 32'hFFFF_FFFF};
    begin_session();
    send_word(32'h1122_3344, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    pulse_start();
    chk("start_in_collect_wc", 64'(word_count), 64'd1);
    chk("start_in_collect_ready", {63'd0, byte_ready}, 64'd1);
    send_byte(8'hEF, 0);
    send_byte(8'h01, 0);
    send_word(32'hFFFF_FFFF, 0);
    end_session("start_ignored");

    // start in DONE begins a new session at address 0.
    stim = '{32'h0000_0055, 32'hFFFF_FFFF};
    run_session("restart", 0);

    // Randomised sessions.
    for (int s = 0; s < 8; s++) begin
      int n;
      n = int'($urandom_range(1, 6));
      stim.delete();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 4) == 0) stim.push_back(32'hFFFF_FFFF);
        else                           stim.push_back($urandom);
      end
      stim.push_back(32'hFFFF_FFFF);
      run_session($sformatf("rand%0d", s), 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
